// File: rtl/register_pkg.sv
// Shared helpers for register blocks: ceil-log2 and occupancy-counter width.
package register_pkg;

  function automatic int clog2(input int value);
    int w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // A counter for 0..depth needs clog2(depth+1) bits, never fewer than one.
  function automatic int count_w(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_stage.sv
// One elastic stage: N-bit data plus valid, loaded when downstream can take it.
// Data only changes alongside a valid word, so bubbles never disturb the payload.
module register_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic         valid_in,
  input  logic [N-1:0] data_in,
  output logic         valid,
  output logic [N-1:0] data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clear)
        valid <= 1'b0;
      else if (load)
        valid <= valid_in;
      if (load && valid_in && !clear)
        data <= data_in;
    end
  end

endmodule

// File: rtl/register_pipeline.sv
// DEPTH-stage valid/ready pipeline, DEPTH cycles latency, combinational ready chain.
// Optional occupancy counter on `count` when REGISTER_PIPELINE_COUNT_EN is defined.
module register_pipeline
  import register_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                din,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                qout,
  output logic [count_w(DEPTH)-1:0]   count
);

  localparam int COUNT_W = count_w(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [N-1:0]     data [DEPTH];
  logic [DEPTH:0]   ready;

  // Walk from the output back to the input so a bubble anywhere frees everything upstream.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      ready[i] = !valid[i] || ready[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         up_valid;
    logic [N-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = din;
    end else begin : g_link
      assign up_valid = valid[i-1];
      assign up_data  = data[i-1];
    end

    register_stage #(.N(N)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (flush),
      .load     (ready[i]),
      .valid_in (up_valid),
      .data_in  (up_data),
      .valid    (valid[i]),
      .data     (data[i])
    );
  end

  assign in_ready  = ready[0] && !flush;
  assign out_valid = valid[DEPTH-1] && !flush;
  assign qout      = data[DEPTH-1];

`ifdef REGISTER_PIPELINE_COUNT_EN
  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (flush)
      count <= '0;
    else if (xfer_in && !xfer_out)
      count <= count + COUNT_W'(1);
    else if (!xfer_in && xfer_out)
      count <= count - COUNT_W'(1);
  end
`else
  assign count = {COUNT_W{1'b0}};
`endif

endmodule
